// File: rtl/mesh_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the systolic mesh tile sequencer.
package mesh_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int kw_of(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int rw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The last operand needs N-1 hops to reach the far corner, plus its own PE register stage.
  function automatic int flush_cycles(input int n, input int pe_lat);
    return (n - 1) * pe_lat + pe_lat;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mesh_skew_gen.sv
// Staircase-skewed lane read enables and k indices: lane i lags lane 0 by i cycles.
module mesh_skew_gen #(
  parameter int N  = 2,
  parameter int KW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            feed,
  input  logic [KW:0]     t_cnt,
  input  logic [KW-1:0]   k_len,
  output logic [N-1:0]    lane_en,
  output logic [N*KW-1:0] lane_k
);
  localparam int TW = KW + 1;

  logic [N-1:0]    en_s;
  logic [N*KW-1:0] k_s;

  // Lane i is live for t in [i, i+K) and reads index t-i.
  always_comb begin
    en_s = {N{1'b0}};
    k_s  = {(N*KW){1'b0}};
    for (int i = 0; i < N; i++) begin
      if (feed && (t_cnt >= TW'(i)) && (t_cnt < (TW'(i) + {1'b0, k_len}))) begin
        en_s[i]            = 1'b1;
        k_s[i*KW +: KW]    = KW'(t_cnt - TW'(i));
      end else begin
        en_s[i]            = 1'b0;
        k_s[i*KW +: KW]    = {KW{1'b0}};
      end
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_en <= {N{1'b0}};
      lane_k  <= {(N*KW){1'b0}};
    end else begin
      lane_en <= en_s;
      lane_k  <= k_s;
    end
  end

endmodule

// File: rtl/mesh_sequencer.sv
// Tile sequencer for the NxN systolic mesh: skewed feed, flush, handshaked row drain.
// Output registers load from the next-state decode so each drain handshake is counted once.
module mesh_sequencer
  import mesh_ctrl_pkg::*;
#(
  parameter int N      = 2,
  parameter int K_MAX  = 256,
  parameter int PE_LAT = 1,
  parameter int KW     = kw_of(K_MAX),
  parameter int RW     = rw_of(N)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [KW-1:0]   k_len_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [N-1:0]    lane_en_o,
  output logic [N*KW-1:0] lane_k_o,
  output logic            inputs_valid_o,
  output logic [N-1:0]    sel_acc_o,
  output logic            drain_valid_o,
  output logic [RW-1:0]   drain_row_o,
  input  logic            drain_ready_i
);
  localparam int TW    = KW + 1;
  localparam int FLUSH = flush_cycles(N, PE_LAT);
  localparam int FW    = cnt_w(FLUSH);

  state_e        state_r, state_nx_s;
  logic [TW-1:0] t_r, t_nx_s, last_s;
  logic [KW-1:0] k_r, k_nx_s;
  logic [RW-1:0] r_r, r_nx_s;
  logic [FW-1:0] fl_r, fl_nx_s;
  logic          err_nx_s, legal_s, feed_nx_s, drain_nx_s;
  logic [N-1:0]  sel_nx_s;

  assign last_s = {1'b0, k_r} + TW'(N - 1) - TW'(1);

  // Next-state and counter update.
  always_comb begin
    state_nx_s = state_r;
    t_nx_s     = t_r;
    k_nx_s     = k_r;
    r_nx_s     = r_r;
    fl_nx_s    = fl_r;
    err_nx_s   = 1'b0;
    legal_s    = (k_len_i != {KW{1'b0}}) && (k_len_i <= KW'(K_MAX));
    if (abort_i && (state_r != ST_IDLE)) begin
      state_nx_s = ST_IDLE;
      t_nx_s     = {TW{1'b0}};
      r_nx_s     = {RW{1'b0}};
      fl_nx_s    = {FW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i && legal_s) begin
            state_nx_s = ST_FEED;
            t_nx_s     = {TW{1'b0}};
            k_nx_s     = k_len_i;
            r_nx_s     = {RW{1'b0}};
            fl_nx_s    = {FW{1'b0}};
          end else if (start_i) begin
            err_nx_s   = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_FEED: begin
          if (t_r == last_s) begin
            state_nx_s = ST_FLUSH;
            t_nx_s     = {TW{1'b0}};
            fl_nx_s    = {FW{1'b0}};
          end else begin
            t_nx_s     = t_r + TW'(1);
          end
        end
        ST_FLUSH: begin
          if (fl_r == FW'(FLUSH - 1)) begin
            state_nx_s = ST_DRAIN;
            r_nx_s     = {RW{1'b0}};
          end else begin
            fl_nx_s    = fl_r + FW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_valid_o && drain_ready_i) begin
            if (r_r == RW'(N - 1)) begin
              state_nx_s = ST_DONE;
            end else begin
              r_nx_s     = r_r + RW'(1);
            end
          end else begin
            state_nx_s = ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_nx_s = ST_IDLE;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Decode of the upcoming state into the drain/feed output values.
  always_comb begin
    feed_nx_s  = (state_nx_s == ST_FEED);
    drain_nx_s = (state_nx_s == ST_DRAIN);
    sel_nx_s   = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (drain_nx_s && (r_nx_s == RW'(i))) begin
        sel_nx_s[i] = 1'b1;
      end else begin
        sel_nx_s[i] = 1'b0;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
      t_r     <= {TW{1'b0}};
      k_r     <= {KW{1'b0}};
      r_r     <= {RW{1'b0}};
      fl_r    <= {FW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      t_r     <= t_nx_s;
      k_r     <= k_nx_s;
      r_r     <= r_nx_s;
      fl_r    <= fl_nx_s;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      inputs_valid_o <= 1'b0;
      sel_acc_o      <= {N{1'b0}};
      drain_valid_o  <= 1'b0;
      drain_row_o    <= {RW{1'b0}};
    end else begin
      busy_o         <= (state_nx_s != ST_IDLE);
      done_o         <= (state_nx_s == ST_DONE);
      err_o          <= err_nx_s;
      inputs_valid_o <= feed_nx_s && (t_nx_s < {1'b0, k_nx_s});
      sel_acc_o      <= sel_nx_s;
      drain_valid_o  <= drain_nx_s;
      drain_row_o    <= drain_nx_s ? r_nx_s : {RW{1'b0}};
    end
  end

  mesh_skew_gen #(.N(N), .KW(KW)) u_skew (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .feed    (feed_nx_s),
    .t_cnt   (t_nx_s),
    .k_len   (k_nx_s),
    .lane_en (lane_en_o),
    .lane_k  (lane_k_o)
  );

endmodule
